// File: rtl/tri_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tri_bus_arbiter
//
// Round-robin arbiter for one shared tri-state bus segment. It produces the
// enables for the per-requester buffer stages so that at most one driver is
// active at a time. Every change of owner passes through a one-cycle all-off
// turnaround, so two drivers never overlap. The selected driver's data is
// mirrored on bus_out_o for observers.
//
// Parameters
//   N_REQ      number of requesters (1..16)
//   BIT_WIDTH  width of each requester's data word and of bus_out_o
//   MAX_HOLD   max consecutive owned cycles per grant, 0 = unlimited
//
// Ports
//   clk_i        single clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset
//   req_i        req_i[i]=1 means requester i wants the bus
//   data_in_i    requester i data at [i*BIT_WIDTH +: BIT_WIDTH]
//   grant_o      registered one-hot (or zero) grant
//   bus_en_o     switch enables, equal to grant_o while owned, else 0
//   bus_out_o    data of the current owner while owned, else 0
//   bus_valid_o  high only while the bus is owned
//   busy_o       high while owned or in the turnaround cycle
// -----------------------------------------------------------------------------
module tri_bus_arbiter #(
   parameter int N_REQ     = 4,
   parameter int BIT_WIDTH = 8,
   parameter int MAX_HOLD  = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [N_REQ-1:0]           req_i,
   input  logic [N_REQ*BIT_WIDTH-1:0] data_in_i,
   output logic [N_REQ-1:0]           grant_o,
   output logic [N_REQ-1:0]           bus_en_o,
   output logic [BIT_WIDTH-1:0]       bus_out_o,
   output logic                       bus_valid_o,
   output logic                       busy_o
);

   localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
   localparam logic [OW-1:0] LAST_IDX  = OW'(N_REQ - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      TURN = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [OW-1:0]     owner_q, owner_d;
   logic [OW-1:0]     rrPtr_q, rrPtr_d;
   logic [HW-1:0]     holdCnt_q, holdCnt_d;
   logic [N_REQ-1:0]  grant_q, grant_d;

   logic              pickValid;
   logic [OW-1:0]     pickIdx;
   logic              hiValid;
   logic [OW-1:0]     hiIdx;
   logic              loValid;
   logic [OW-1:0]     loIdx;
   logic              leaveOwn;
   logic [BIT_WIDTH-1:0] busOut;

   // Round-robin pick: the lowest requesting index at or above the pointer
   // wins; if none exists the search wraps to the lowest requesting index
   // overall. Loops run downward so the last hit is the lowest index.
   always_comb begin
      hiValid = 1'b0;
      hiIdx   = '0;
      loValid = 1'b0;
      loIdx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            loValid = 1'b1;
            loIdx   = OW'(i);
            if (i >= int'(rrPtr_q)) begin
               hiValid = 1'b1;
               hiIdx   = OW'(i);
            end
         end
      end
      pickValid = loValid;
      pickIdx   = hiValid ? hiIdx : loIdx;
   end

   // The owner gives the bus up when it stops requesting or when it has used
   // its full hold budget; with MAX_HOLD of zero only the request matters and
   // the hold counter is free to wrap.
   always_comb begin
      leaveOwn = !req_i[owner_q];
      if (MAX_HOLD != 0 && holdCnt_q == HOLD_LAST) begin
         leaveOwn = 1'b1;
      end
   end

   // Next-state logic. IDLE and TURN arbitrate identically; TURN always lasts
   // a single cycle with everything off, which is what separates two owners.
   // The pointer moves past the owner as it leaves, so the turnaround cycle
   // already arbitrates with the advanced pointer.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rrPtr_d   = rrPtr_q;
      holdCnt_d = holdCnt_q;
      grant_d   = grant_q;
      case (state_q)
         IDLE, TURN: begin
            grant_d = '0;
            if (pickValid) begin
               state_d          = OWN;
               owner_d          = pickIdx;
               holdCnt_d        = '0;
               grant_d[pickIdx] = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         OWN: begin
            if (leaveOwn) begin
               state_d = TURN;
               grant_d = '0;
               rrPtr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
            end else begin
               holdCnt_d = holdCnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State register. Reset drops every enable on the same edge, even in the
   // middle of a grant, without a turnaround.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         rrPtr_q   <= '0;
         holdCnt_q <= '0;
         grant_q   <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rrPtr_q   <= rrPtr_d;
         holdCnt_q <= holdCnt_d;
         grant_q   <= grant_d;
      end
   end

   // Observer data: the grant is one-hot while owned, so selecting by grant
   // bit yields exactly the owner's slice, and zero otherwise.
   always_comb begin
      busOut = '0;
      if (state_q == OWN) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
               busOut = data_in_i[i*BIT_WIDTH +: BIT_WIDTH];
            end
         end
      end
   end

   assign grant_o     = grant_q;
   assign bus_en_o    = (state_q == OWN) ? grant_q : '0;
   assign bus_valid_o = (state_q == OWN);
   assign busy_o      = (state_q != IDLE);
   assign bus_out_o   = busOut;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tri_bus_arbiter
//
// Drives three arbiters (MAX_HOLD of 4, 0 and 2) from the same request and
// data inputs and compares every output each cycle against a reference model
// that tracks only who owns the bus, how long it has owned it, whether a
// turnaround is in progress and where the round-robin search starts.
// -----------------------------------------------------------------------------
module tb_tri_bus_arbiter;

   localparam int N = 4;
   localparam int W = 8;
   localparam int NI = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] dataIn;

   logic [N-1:0] grant0, grant1, grant2;
   logic [N-1:0] busEn0, busEn1, busEn2;
   logic [W-1:0] busOut0, busOut1, busOut2;
   logic         valid0, valid1, valid2;
   logic         busy0, busy1, busy2;

   int errors = 0;
   int checks = 0;

   int maxHold[NI] = '{4, 0, 2};
   int mOwner[NI];
   int mTurn[NI];
   int mPtr[NI];
   int mRun[NI];

   // Free-running clock.
   always #5 clk = ~clk;

   tri_bus_arbiter #(.N_REQ(N), .BIT_WIDTH(W), .MAX_HOLD(4)) dut0 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .data_in_i(dataIn),
      .grant_o(grant0), .bus_en_o(busEn0), .bus_out_o(busOut0),
      .bus_valid_o(valid0), .busy_o(busy0)
   );

   tri_bus_arbiter #(.N_REQ(N), .BIT_WIDTH(W), .MAX_HOLD(0)) dut1 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .data_in_i(dataIn),
      .grant_o(grant1), .bus_en_o(busEn1), .bus_out_o(busOut1),
      .bus_valid_o(valid1), .busy_o(busy1)
   );

   tri_bus_arbiter #(.N_REQ(N), .BIT_WIDTH(W), .MAX_HOLD(2)) dut2 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .data_in_i(dataIn),
      .grant_o(grant2), .bus_en_o(busEn2), .bus_out_o(busOut2),
      .bus_valid_o(valid2), .busy_o(busy2)
   );

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance the reference model of arbiter k across one rising edge.
   task automatic modelStep(input int k);
      if (rst) begin
         mOwner[k] = -1;
         mTurn[k]  = 0;
         mPtr[k]   = 0;
         mRun[k]   = 0;
      end else if (mOwner[k] >= 0) begin
         if (!req[mOwner[k]] || (maxHold[k] != 0 && mRun[k] == maxHold[k])) begin
            mPtr[k]   = (mOwner[k] + 1) % N;
            mOwner[k] = -1;
            mTurn[k]  = 1;
         end else begin
            mRun[k] = mRun[k] + 1;
         end
      end else begin
         mTurn[k] = 0;
         for (int j = 0; j < N; j++) begin
            if (mOwner[k] < 0 && req[(mPtr[k] + j) % N]) begin
               mOwner[k] = (mPtr[k] + j) % N;
               mRun[k]   = 1;
            end
         end
      end
   endtask

   // Compare all outputs of arbiter k against the model.
   task automatic checkInst(input int k, input logic [N-1:0] g, input logic [N-1:0] e,
                            input logic [W-1:0] o, input logic v, input logic b);
      int expGrant;
      int expOut;
      expGrant = (mOwner[k] >= 0) ? (1 << mOwner[k]) : 0;
      expOut   = (mOwner[k] >= 0) ? int'((dataIn >> (W * mOwner[k])) & 32'hFF) : 0;
      checkOutput($sformatf("grant%0d", k),  32'(g), 32'(expGrant));
      checkOutput($sformatf("busEn%0d", k),  32'(e), 32'(expGrant));
      checkOutput($sformatf("busOut%0d", k), 32'(o), 32'(expOut));
      checkOutput($sformatf("valid%0d", k),  32'(v), 32'(mOwner[k] >= 0));
      checkOutput($sformatf("busy%0d", k),   32'(b), 32'(mOwner[k] >= 0 || mTurn[k] != 0));
   endtask

   // One clock of stimulus: inputs change at the falling edge, the model
   // advances at the rising edge, outputs are checked at the next falling edge.
   task automatic applyStimulus(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] d);
      rst    = r;
      req    = rq;
      dataIn = d;
      @(posedge clk);
      for (int k = 0; k < NI; k++) modelStep(k);
      @(negedge clk);
      checkInst(0, grant0, busEn0, busOut0, valid0, busy0);
      checkInst(1, grant1, busEn1, busOut1, valid1, busy1);
      checkInst(2, grant2, busEn2, busOut2, valid2, busy2);
   endtask

   initial begin
      logic [N-1:0] rq;
      int turnSeen;
      for (int k = 0; k < NI; k++) begin
         mOwner[k] = -1;
         mTurn[k]  = 0;
         mPtr[k]   = 0;
         mRun[k]   = 0;
      end
      rst    = 1'b1;
      req    = '0;
      dataIn = '0;

      // Reset, then idle with no requests.
      repeat (2) applyStimulus(1'b1, 4'b0000, $urandom);
      repeat (5) applyStimulus(1'b0, 4'b0000, $urandom);
      checkOutput("idleBusy", 32'(busy0), 32'd0);

      // Single requester 1 with fixed data, held three cycles then dropped.
      repeat (3) applyStimulus(1'b0, 4'b0010, 32'h0000A500);
      checkOutput("t2BusOut", 32'(busOut0), 32'hA5);
      checkOutput("t2Grant",  32'(grant0), 32'b0010);
      applyStimulus(1'b0, 4'b0000, 32'h0000A500);
      checkOutput("t2Turn", 32'(busy0 && !valid0), 32'd1);
      applyStimulus(1'b0, 4'b0000, 32'h0000A500);
      checkOutput("t2Idle", 32'(busy0), 32'd0);

      // All requesting: rotation with hold limits and turnarounds.
      repeat (45) applyStimulus(1'b0, 4'b1111, $urandom);

      // Lone requester 0: repeated OWN runs separated by single TURN cycles.
      applyStimulus(1'b1, 4'b0000, $urandom);
      repeat (12) applyStimulus(1'b0, 4'b0001, $urandom);

      // Reset while requester 2 owns the bus, then requesters 1 and 2 compete.
      repeat (2) applyStimulus(1'b0, 4'b0100, $urandom);
      checkOutput("t5Owner2", 32'(grant0), 32'b0100);
      applyStimulus(1'b1, 4'b0110, $urandom);
      checkOutput("t5RstGrant", 32'(grant0), 32'd0);
      applyStimulus(1'b0, 4'b0110, $urandom);
      checkOutput("t5Grant1", 32'(grant0), 32'b0010);

      // Unlimited hold: instance 1 must never leave OWN.
      applyStimulus(1'b1, 4'b0000, $urandom);
      turnSeen = 0;
      repeat (100) begin
         applyStimulus(1'b0, 4'b0001, $urandom);
         if (mOwner[1] >= 0 && !valid1) turnSeen++;
      end
      checkOutput("t6NoTurn", 32'(turnSeen), 32'd0);
      checkOutput("t6Valid", 32'(valid1), 32'd1);

      // Random traffic with occasional resets and sticky requests.
      rq = '0;
      repeat (400) begin
         if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
         applyStimulus(($urandom_range(0, 49) == 0), rq, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
